// File: rtl/p_dispatch_ctrl_if.sv
// rtl/p_dispatch_ctrl_if.sv - rename-side and issue-queue-side bus of the dispatch scheduler
// master drives rename slots and queue returns; slave is the scheduler.
interface p_dispatch_ctrl_if #(
  parameter int CW = 4
);
  logic [1:0]          r_valid_i;
  logic [1:0]          alu_type_i;
  logic [1:0]          mdu_type_i;
  logic [1:0]          lsu_type_i;
  logic                r_ready_o;
  logic [1:0][1:0]     alu_choose_o;
  logic [1:0]          mdu_choose_o;
  logic [1:0]          lsu_choose_o;
  logic [3:0]          q_valid_o;
  logic [3:0][1:0]     q_ret_i;
  logic [3:0][CW-1:0]  credit_o;

  modport master (
    output r_valid_i, alu_type_i, mdu_type_i, lsu_type_i, q_ret_i,
    input  r_ready_o, alu_choose_o, mdu_choose_o, lsu_choose_o, q_valid_o, credit_o
  );

  modport slave (
    input  r_valid_i, alu_type_i, mdu_type_i, lsu_type_i, q_ret_i,
    output r_ready_o, alu_choose_o, mdu_choose_o, lsu_choose_o, q_valid_o, credit_o
  );
endinterface

// File: rtl/p_dispatch_ctrl.sv
// rtl/p_dispatch_ctrl.sv - credit-based dispatch scheduler for alu0/alu1/mdu/lsu issue queues
// Optional DISPATCH_PERF_CNT_EN adds perf_stall_o / perf_flush_o counters.
module p_dispatch_ctrl #(
  parameter int ALU_DEPTH    = 8,
  parameter int MDU_DEPTH    = 4,
  parameter int LSU_DEPTH    = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  p_dispatch_ctrl_if.slave    bus,
  output logic                err_o
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_stall_o,
  output logic [31:0]         perf_flush_o
`endif
);

  localparam int MAX_AM = (ALU_DEPTH > MDU_DEPTH) ? ALU_DEPTH : MDU_DEPTH;
  localparam int MAX_D  = (MAX_AM > LSU_DEPTH) ? MAX_AM : LSU_DEPTH;
  localparam int CW     = $clog2(MAX_D + 1);
  localparam int SW     = CW + 2;
  localparam int FCW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

  function automatic logic [SW-1:0] depth_of(input int q);
    case (q)
      0, 1:    depth_of = SW'(ALU_DEPTH);
      2:       depth_of = SW'(MDU_DEPTH);
      default: depth_of = SW'(LSU_DEPTH);
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [FCW-1:0]     cnt_q, cnt_d;
  logic [3:0][CW-1:0] credit_q, credit_d;
  logic               tie_q, tie_d;
  logic               err_q, err_d;

  logic [1:0]         slot_alu, slot_mdu, slot_lsu, slot_bad;
  logic [1:0]         n_types;
  logic [1:0][1:0]    steer;
  logic               alu_q;
  logic               tie_used;
  logic [3:0][1:0]    demand;
  logic               credit_ok;
  logic               ready;
  logic [3:0][SW-1:0] sum;

  // Slot classification: exactly one type bit selects a queue; none is ROB-only.
  always_comb begin
    slot_alu = '0;
    slot_mdu = '0;
    slot_lsu = '0;
    slot_bad = '0;
    n_types  = '0;
    for (int s = 0; s < 2; s++) begin
      n_types     = 2'(bus.alu_type_i[s]) + 2'(bus.mdu_type_i[s]) + 2'(bus.lsu_type_i[s]);
      slot_bad[s] = bus.r_valid_i[s] && (n_types > 2'd1);
      slot_alu[s] = bus.r_valid_i[s] && (n_types == 2'd1) && bus.alu_type_i[s];
      slot_mdu[s] = bus.r_valid_i[s] && (n_types == 2'd1) && bus.mdu_type_i[s];
      slot_lsu[s] = bus.r_valid_i[s] && (n_types == 2'd1) && bus.lsu_type_i[s];
    end
  end

  always_comb begin
    steer    = '0;
    tie_used = 1'b0;
    alu_q    = 1'b0;
    if (slot_alu == 2'b11) begin
      steer[0][0] = 1'b1;
      steer[1][1] = 1'b1;
    end else if (|slot_alu) begin
      if (credit_q[0] > credit_q[1]) begin
        alu_q = 1'b0;
      end else if (credit_q[1] > credit_q[0]) begin
        alu_q = 1'b1;
      end else begin
        alu_q    = tie_q;
        tie_used = 1'b1;
      end
      steer[alu_q] = slot_alu;
    end
    demand[0] = {1'b0, steer[0][0]} + {1'b0, steer[0][1]};
    demand[1] = {1'b0, steer[1][0]} + {1'b0, steer[1][1]};
    demand[2] = {1'b0, slot_mdu[0]} + {1'b0, slot_mdu[1]};
    demand[3] = {1'b0, slot_lsu[0]} + {1'b0, slot_lsu[1]};
    credit_ok = 1'b1;
    for (int q = 0; q < 4; q++) begin
      if (credit_q[q] < CW'(demand[q])) credit_ok = 1'b0;
    end
  end

  // Output process: the whole pair pushes or nothing does.
  always_comb begin
    ready = (state_q == ST_RUN) && !rst && !flush_i && credit_ok && !(|slot_bad);
  end

  assign bus.r_ready_o       = ready;
  assign bus.alu_choose_o[0] = steer[0] & {2{ready}};
  assign bus.alu_choose_o[1] = steer[1] & {2{ready}};
  assign bus.mdu_choose_o    = slot_mdu & {2{ready}};
  assign bus.lsu_choose_o    = slot_lsu & {2{ready}};
  assign bus.q_valid_o       = {ready && |slot_lsu, ready && |slot_mdu,
                                ready && |steer[1], ready && |steer[0]};
  assign bus.credit_o        = credit_q;
  assign err_o               = err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    credit_d = credit_q;
    tie_d    = tie_q;
    err_d    = err_q | (|slot_bad);
    sum      = '0;
    case (state_q)
      ST_RUN: begin
        for (int q = 0; q < 4; q++) begin
          sum[q] = SW'(credit_q[q]) + SW'(bus.q_ret_i[q]) - (ready ? SW'(demand[q]) : SW'(0));
          if (sum[q] > depth_of(q)) begin
            credit_d[q] = CW'(depth_of(q));
            err_d       = 1'b1;
          end else begin
            credit_d[q] = sum[q][CW-1:0];
          end
        end
        if (ready && tie_used) tie_d = ~tie_q;
        if (flush_i) begin
          state_d = ST_FLUSH;
          cnt_d   = FCW'(FLUSH_CYCLES - 1);
        end
      end
      default: begin
        // Returns are ignored while draining; credits are rebuilt from depths on exit.
        if (flush_i) begin
          cnt_d = FCW'(FLUSH_CYCLES - 1);
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
          for (int q = 0; q < 4; q++) credit_d[q] = CW'(depth_of(q));
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      tie_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int q = 0; q < 4; q++) credit_q[q] <= CW'(depth_of(q));
    end else begin
      for (int q = 0; q < 4; q++) begin
        assert (!ready || credit_q[q] >= CW'(demand[q]));
      end
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tie_q    <= tie_d;
      err_q    <= err_d;
      credit_q <= credit_d;
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (state_q == ST_RUN && |bus.r_valid_i && !ready) perf_stall_d = perf_stall_q + 32'd1;
    if (state_q == ST_FLUSH) perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_flush_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_p_dispatch_ctrl.sv
// tb/tb_p_dispatch_ctrl.sv - self-checking bench for p_dispatch_ctrl with a behavioural model
module tb_p_dispatch_ctrl;
  localparam int CW = 4;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush_i = 1'b0;
  logic err_o;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] perf_stall, perf_flush;
`endif

  p_dispatch_ctrl_if #(.CW(CW)) bus ();

  p_dispatch_ctrl #(
    .ALU_DEPTH(8), .MDU_DEPTH(4), .LSU_DEPTH(8), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .bus(bus.slave), .err_o(err_o)
`ifdef DISPATCH_PERF_CNT_EN
    , .perf_stall_o(perf_stall), .perf_flush_o(perf_flush)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int depth(input int q);
    return (q == 2) ? 4 : 8;
  endfunction

  // Model state: queue free counts, tie pointer, sticky error, FLUSH cycles left (0 = running).
  int m_cred[4];
  bit m_tie, m_err, m_valid = 1'b0;
  int m_left;

  int  need[4];
  int  kind[2];
  int  tgt[2];
  bit  bad, tie_used, ok;
  int  n_alu, nt, q_alu, c;
  logic [3:0] e_alu, e_qv;
  logic [1:0] e_mdu, e_lsu;

  always @(negedge clk) begin
    bad = 0; tie_used = 0; n_alu = 0; q_alu = 0;
    e_alu = '0; e_qv = '0; e_mdu = '0; e_lsu = '0;
    for (int q = 0; q < 4; q++) need[q] = 0;
    for (int s = 0; s < 2; s++) begin
      nt = int'(bus.alu_type_i[s]) + int'(bus.mdu_type_i[s]) + int'(bus.lsu_type_i[s]);
      kind[s] = 0;
      tgt[s] = 0;
      if (bus.r_valid_i[s]) begin
        if (nt > 1) bad = 1;
        else if (nt == 1) kind[s] = bus.alu_type_i[s] ? 1 : (bus.mdu_type_i[s] ? 2 : 3);
      end
      if (kind[s] == 1) n_alu++;
    end
    if (n_alu == 2) begin
      tgt[0] = 0; tgt[1] = 1;
    end else if (n_alu == 1) begin
      if (m_cred[0] > m_cred[1]) q_alu = 0;
      else if (m_cred[1] > m_cred[0]) q_alu = 1;
      else begin q_alu = m_tie ? 1 : 0; tie_used = 1; end
      tgt[0] = q_alu; tgt[1] = q_alu;
    end
    for (int s = 0; s < 2; s++) begin
      if (kind[s] == 1) need[tgt[s]]++;
      else if (kind[s] == 2) need[2]++;
      else if (kind[s] == 3) need[3]++;
    end
    ok = !rst && (m_left == 0) && !flush_i && !bad;
    for (int q = 0; q < 4; q++) if (need[q] > m_cred[q]) ok = 0;
    for (int s = 0; s < 2; s++) begin
      if (ok && kind[s] == 1) e_alu[tgt[s]*2 + s] = 1'b1;
      if (ok && kind[s] == 2) e_mdu[s] = 1'b1;
      if (ok && kind[s] == 3) e_lsu[s] = 1'b1;
    end
    for (int q = 0; q < 4; q++) e_qv[q] = ok && (need[q] > 0);

    if (m_valid) begin
      chk("m_ready", bus.r_ready_o, ok);
      chk("m_alu_choose", bus.alu_choose_o, e_alu);
      chk("m_mdu_choose", bus.mdu_choose_o, e_mdu);
      chk("m_lsu_choose", bus.lsu_choose_o, e_lsu);
      chk("m_q_valid", bus.q_valid_o, e_qv);
      for (int q = 0; q < 4; q++) chk($sformatf("m_credit%0d", q), bus.credit_o[q], m_cred[q]);
      chk("m_err", err_o, m_err);
    end

    if (rst) begin
      for (int q = 0; q < 4; q++) m_cred[q] = depth(q);
      m_tie = 0; m_err = 0; m_left = 0; m_valid = 1;
    end else if (m_valid) begin
      if (bad) m_err = 1;
      if (m_left == 0) begin
        for (int q = 0; q < 4; q++) begin
          c = m_cred[q] - (ok ? need[q] : 0) + int'(bus.q_ret_i[q]);
          if (c > depth(q)) begin c = depth(q); m_err = 1; end
          m_cred[q] = c;
        end
        if (ok && tie_used) m_tie = !m_tie;
        if (flush_i) m_left = FC;
      end else if (flush_i) begin
        m_left = FC;
      end else begin
        m_left--;
        if (m_left == 0) for (int q = 0; q < 4; q++) m_cred[q] = depth(q);
      end
    end
  end

  task automatic put(input logic [1:0] v, input logic [1:0] a, input logic [1:0] m,
                     input logic [1:0] l, input logic [7:0] ret, input logic fl);
    bus.r_valid_i  = v;
    bus.alu_type_i = a;
    bus.mdu_type_i = m;
    bus.lsu_type_i = l;
    bus.q_ret_i    = ret;
    flush_i        = fl;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_put();
    logic [1:0] v, a, m, l;
    logic [7:0] ret;
    int r;
    for (int s = 0; s < 2; s++) begin
      r = $urandom_range(0, 15);
      v[s] = 1'b1; a[s] = 1'b0; m[s] = 1'b0; l[s] = 1'b0;
      if (r < 3) begin
        v[s] = 1'b0; a[s] = 1'($urandom); m[s] = 1'($urandom); l[s] = 1'($urandom);
      end else if (r < 8) a[s] = 1'b1;
      else if (r < 10) m[s] = 1'b1;
      else if (r < 12) l[s] = 1'b1;
      else if (r < 13) ;
      else if (r == 15 && $urandom_range(0, 7) == 0) begin a[s] = 1'b1; l[s] = 1'b1; end
      else a[s] = 1'b1;
    end
    for (int q = 0; q < 4; q++) begin
      if ($urandom_range(0, 49) == 0) r = $urandom_range(0, 2);
      else if ($urandom_range(0, 2) == 0) begin
        r = depth(q) - m_cred[q];
        if (r > 2) r = 2;
        r = (r > 0) ? $urandom_range(0, r) : 0;
      end else r = 0;
      ret[q*2 +: 2] = 2'(r);
    end
    put(v, a, m, l, ret, $urandom_range(0, 30) == 0);
  endtask

  initial begin
    put(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) adv();
    @(negedge clk);
    chk("rst_ready", bus.r_ready_o, 0);
    chk("rst_qvalid", bus.q_valid_o, 0);
    chk("rst_cred_alu0", bus.credit_o[0], 8);
    chk("rst_cred_mdu", bus.credit_o[2], 4);
    chk("rst_cred_lsu", bus.credit_o[3], 8);
    chk("rst_err", err_o, 0);
    adv();
    rst = 1'b0;

    put(2'b11, 2'b11, 0, 0, 0, 0);
    @(negedge clk);
    chk("aa_ready", bus.r_ready_o, 1);
    chk("aa_choose0", bus.alu_choose_o[0], 2'b01);
    chk("aa_choose1", bus.alu_choose_o[1], 2'b10);
    adv();
    put(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("aa_cred0", bus.credit_o[0], 7);
    chk("aa_cred1", bus.credit_o[1], 7);
    adv();
    repeat (4) begin put(2'b11, 2'b11, 0, 0, 0, 0); adv(); end
    put(0, 0, 0, 0, 8'h08, 0); adv();
    put(2'b01, 2'b01, 0, 0, 0, 0);
    @(negedge clk);
    chk("steer_more_qv", bus.q_valid_o, 4'b0010);
    chk("steer_more_ch1", bus.alu_choose_o[1], 2'b01);
    adv();
    put(0, 0, 0, 0, 8'h01, 0); adv();
    put(2'b10, 2'b10, 0, 0, 0, 0);
    @(negedge clk);
    chk("tie_ptr0_qv", bus.q_valid_o, 4'b0001);
    adv();
    put(2'b01, 2'b01, 0, 0, 0, 0);
    @(negedge clk);
    chk("after_tie_qv", bus.q_valid_o, 4'b0010);
    adv();
    put(2'b01, 2'b01, 0, 0, 0, 0);
    @(negedge clk);
    chk("tie_ptr1_qv", bus.q_valid_o, 4'b0010);
    adv();

    put(2'b11, 0, 2'b11, 0, 0, 0); adv();
    put(2'b01, 0, 2'b01, 0, 0, 0); adv();
    put(2'b11, 0, 2'b11, 0, 8'h10, 0);
    @(negedge clk);
    chk("mdu_stall_ready", bus.r_ready_o, 0);
    chk("mdu_stall_qv", bus.q_valid_o, 0);
    adv();
    put(2'b11, 0, 2'b11, 0, 0, 0);
    @(negedge clk);
    chk("mdu_go_ready", bus.r_ready_o, 1);
    chk("mdu_go_qv", bus.q_valid_o, 4'b0100);
    adv();
    put(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mdu_cred", bus.credit_o[2], 0);
    adv();

    repeat (4) begin put(2'b11, 0, 0, 2'b11, 0, 0); adv(); end
    put(2'b01, 0, 0, 2'b01, 8'h80, 0);
    @(negedge clk);
    chk("lsu_full_ready", bus.r_ready_o, 0);
    adv();
    put(2'b01, 0, 0, 2'b01, 8'h40, 0);
    @(negedge clk);
    chk("lsu_net_ready", bus.r_ready_o, 1);
    chk("lsu_net_qv", bus.q_valid_o, 4'b1000);
    adv();
    put(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lsu_net_cred", bus.credit_o[3], 2);
    adv();

    put(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("flush_same_ready", bus.r_ready_o, 0);
    adv();
    put(2'b11, 2'b11, 0, 0, 8'h02, 0);
    @(negedge clk);
    chk("flush1_ready", bus.r_ready_o, 0);
    chk("flush1_qv", bus.q_valid_o, 0);
    adv();
    put(2'b11, 2'b11, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush2_ready", bus.r_ready_o, 0);
    adv();
    @(negedge clk);
    chk("flush_done_ready", bus.r_ready_o, 1);
    chk("flush_done_cred0", bus.credit_o[0], 8);
    chk("flush_done_cred2", bus.credit_o[2], 4);
    chk("flush_done_cred3", bus.credit_o[3], 8);
    chk("flush_done_err", err_o, 0);
    adv();

    put(0, 0, 0, 0, 0, 1); adv();
    put(0, 0, 0, 0, 0, 0); adv();
    put(0, 0, 0, 0, 0, 1); adv();
    put(2'b11, 2'b11, 0, 0, 0, 0);
    @(negedge clk);
    chk("reflush_a_ready", bus.r_ready_o, 0);
    adv();
    @(negedge clk);
    chk("reflush_b_ready", bus.r_ready_o, 0);
    adv();
    @(negedge clk);
    chk("reflush_done_ready", bus.r_ready_o, 1);
    adv();

    put(2'b01, 2'b01, 2'b01, 0, 0, 0);
    @(negedge clk);
    chk("bad_ready", bus.r_ready_o, 0);
    adv();
    put(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("bad_err", err_o, 1);
    repeat (3) adv();
    @(negedge clk);
    chk("bad_err_sticky", err_o, 1);
    rst = 1'b1; adv(); rst = 1'b0;
    @(negedge clk);
    chk("bad_err_cleared", err_o, 0);
    adv();

    put(0, 0, 0, 0, 8'h01, 0); adv();
    put(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sat_cred0", bus.credit_o[0], 8);
    chk("sat_err", err_o, 1);
    rst = 1'b1; adv(); rst = 1'b0;

    repeat (4000) begin
      rand_put();
      rst = ($urandom_range(0, 149) == 0);
      adv();
    end
    rst = 1'b0;
    put(0, 0, 0, 0, 0, 0);
    adv();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
